// File: rtl/dr_pkg.sv
// dr_pkg: shared state encoding and dual-rail code points
package dr_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_DATA, DONE, ERR} state_t;

    // Codes are written {rail_1, rail_0}
    localparam logic [1:0] DR_NULL = 2'b00;
    localparam logic [1:0] DR_ZERO = 2'b01;
    localparam logic [1:0] DR_ONE  = 2'b10;
    localparam logic [1:0] DR_ILL  = 2'b11;

endpackage

// File: rtl/dr_classify.sv
// dr_classify: per-bundle dual-rail completion / spacer / illegal detection
module dr_classify
    import dr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rail_1,
    input  logic [WIDTH-1:0] rail_0,
    output logic             all_valid,
    output logic             all_null,
    output logic             any_illegal,
    output logic [WIDTH-1:0] value
);

    assign value = rail_1;

    // Fold every bit's code into the three bundle-wide flags
    always_comb begin
        all_valid   = 1'b1;
        all_null    = 1'b1;
        any_illegal = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            all_valid   = all_valid & (({rail_1[i], rail_0[i]} == DR_ZERO) | ({rail_1[i], rail_0[i]} == DR_ONE));
            all_null    = all_null & ({rail_1[i], rail_0[i]} == DR_NULL);
            any_illegal = any_illegal | ({rail_1[i], rail_0[i]} == DR_ILL);
        end
    end

endmodule

// File: rtl/dr_completion_ctrl.sv
// dr_completion_ctrl: four-phase go/done completion controller for a dual-rail bundle
module dr_completion_ctrl
    import dr_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int REQUIRE_NULL = 1,
    parameter int TIMEOUT      = 255,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_0,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             err_illegal,
    output logic             err_timeout,
    output logic             busy,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t           state;
    logic             go_q;
    logic [WIDTH-1:0] d1_q;
    logic [WIDTH-1:0] d0_q;
    logic [TW-1:0]    timer;
    logic             all_valid;
    logic             all_null;
    logic             any_illegal;
    logic [WIDTH-1:0] value;
    logic             expire;
    logic             exit_ok;

    dr_classify #(.WIDTH(WIDTH)) u_classify (
        .rail_1      (d1_q),
        .rail_0      (d0_q),
        .all_valid   (all_valid),
        .all_null    (all_null),
        .any_illegal (any_illegal),
        .value       (value)
    );

    assign expire  = (TIMEOUT != 0) && (timer == T_LAST);
    assign exit_ok = !go_q && (all_null || (REQUIRE_NULL == 0));
    assign busy    = (state != IDLE);

    // Input register, handshake FSM, timer and word counter; timer restarts on every state change
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            go_q        <= 1'b0;
            d1_q        <= '0;
            d0_q        <= '0;
            timer       <= '0;
            done        <= 1'b0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
            word_cnt    <= '0;
        end else begin
            go_q      <= go;
            d1_q      <= data_1;
            d0_q      <= data_0;
            valid_out <= 1'b0;
            done      <= 1'b0;
            timer     <= '0;
            case (state)
                IDLE: state <= go_q ? WAIT_DATA : IDLE;
                WAIT_DATA: begin
                    if (any_illegal) begin
                        state       <= ERR;
                        err_illegal <= 1'b1;
                    end else if (!go_q) begin
                        state <= IDLE;
                    end else if (all_valid) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        valid_out <= 1'b1;
                        data_out  <= value;
                        word_cnt  <= word_cnt + 1'b1;
                    end else if (expire) begin
                        state       <= ERR;
                        err_timeout <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: begin
                    if (any_illegal) begin
                        state       <= ERR;
                        err_illegal <= 1'b1;
                    end else if (exit_ok) begin
                        state <= IDLE;
                    end else if (expire) begin
                        state       <= ERR;
                        err_timeout <= 1'b1;
                    end else begin
                        done  <= 1'b1;
                        timer <= timer + 1'b1;
                    end
                end
                ERR: begin
                    if (!go_q && all_null) begin
                        state       <= IDLE;
                        err_illegal <= 1'b0;
                        err_timeout <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dr_completion_ctrl.sv
// tb_dr_completion_ctrl: directed and random checks of two controller configurations against a behavioural model
module tb_dr_completion_ctrl;
    import dr_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       go = 1'b0;
    logic [7:0] d1 = 8'h00;
    logic [7:0] d0 = 8'h00;

    logic       a_done, a_valid, a_ei, a_et, a_busy;
    logic [7:0] a_data;
    logic [1:0] a_cnt;
    logic       b_done, b_valid, b_ei, b_et, b_busy;
    logic [7:0] b_data;
    logic [7:0] b_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dr_completion_ctrl #(.WIDTH(8), .REQUIRE_NULL(1), .TIMEOUT(4), .CNT_W(2)) dut_a (
        .clk(clk), .reset(reset), .go(go), .data_1(d1), .data_0(d0),
        .done(a_done), .data_out(a_data), .valid_out(a_valid),
        .err_illegal(a_ei), .err_timeout(a_et), .busy(a_busy), .word_cnt(a_cnt)
    );

    dr_completion_ctrl #(.WIDTH(8), .REQUIRE_NULL(0), .TIMEOUT(0), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .go(go), .data_1(d1), .data_0(d0),
        .done(b_done), .data_out(b_data), .valid_out(b_valid),
        .err_illegal(b_ei), .err_timeout(b_et), .busy(b_busy), .word_cnt(b_cnt)
    );

    // Model: index 0 mirrors dut_a's configuration, index 1 dut_b's
    int         rn[2] = '{1, 0};
    int         to[2] = '{4, 0};
    int         cw[2] = '{2, 8};
    int         ph[2];
    int         age[2];
    logic       qg[2];
    logic [7:0] q1[2], q0[2], dat[2];
    logic       val[2], ei[2], et[2];
    int         cnt[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Phases: 0 idle, 1 waiting for a word, 2 acknowledged, 3 error
    task automatic model_step(input int i);
        int nv, nn, ni;
        logic full, empty, ill, late;
        int nxt;
        nv = 0; nn = 0; ni = 0;
        if (!reset) begin
            ph[i] = 0; age[i] = 0; qg[i] = 0; q1[i] = 0; q0[i] = 0;
            dat[i] = 0; val[i] = 0; ei[i] = 0; et[i] = 0; cnt[i] = 0;
            return;
        end
        for (int b = 0; b < 8; b++) begin
            if ({q1[i][b], q0[i][b]} == DR_ZERO || {q1[i][b], q0[i][b]} == DR_ONE) nv++;
            if ({q1[i][b], q0[i][b]} == DR_NULL) nn++;
            if ({q1[i][b], q0[i][b]} == DR_ILL) ni++;
        end
        full  = (nv == 8);
        empty = (nn == 8);
        ill   = (ni > 0);
        late  = (to[i] != 0) && (age[i] == to[i] - 1);
        val[i] = 0;
        nxt = ph[i];
        if (ph[i] == 0) begin
            if (qg[i]) nxt = 1;
        end else if (ph[i] == 3) begin
            if (!qg[i] && empty) begin nxt = 0; ei[i] = 0; et[i] = 0; end
        end else if (ill) begin
            nxt = 3; ei[i] = 1;
        end else if (ph[i] == 1 && !qg[i]) begin
            nxt = 0;
        end else if (ph[i] == 2 && !qg[i] && (empty || rn[i] == 0)) begin
            nxt = 0;
        end else if (ph[i] == 1 && full) begin
            nxt = 2; val[i] = 1; dat[i] = q1[i]; cnt[i] = (cnt[i] + 1) % (1 << cw[i]);
        end else if (late) begin
            nxt = 3; et[i] = 1;
        end
        age[i] = (nxt == ph[i] && (ph[i] == 1 || ph[i] == 2)) ? age[i] + 1 : 0;
        ph[i] = nxt;
        qg[i] = go; q1[i] = d1; q0[i] = d0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check("a_done", a_done, ph[0] == 2);
        check("a_valid", a_valid, val[0]);
        check("a_data", a_data, dat[0]);
        check("a_err_ill", a_ei, ei[0]);
        check("a_err_to", a_et, et[0]);
        check("a_busy", a_busy, ph[0] != 0);
        check("a_cnt", a_cnt, cnt[0]);
        check("b_done", b_done, ph[1] == 2);
        check("b_valid", b_valid, val[1]);
        check("b_data", b_data, dat[1]);
        check("b_err_ill", b_ei, ei[1]);
        check("b_err_to", b_et, et[1]);
        check("b_busy", b_busy, ph[1] != 0);
        check("b_cnt", b_cnt, cnt[1]);
    endtask

    task automatic drive(input logic g, input logic [7:0] mask, input logic [7:0] v);
        go = g;
        d1 = v & mask;
        d0 = ~v & mask;
    endtask

    task automatic handshake(input logic [7:0] v);
        drive(1'b1, 8'h00, 8'h00); tick();
        drive(1'b1, 8'hFF, v);     tick(); tick();
        drive(1'b0, 8'h00, 8'h00); tick(); tick();
    endtask

    initial begin
        int pulses;
        int saved;
        logic [7:0] m;
        // Reset
        tick(); tick();
        check("rst_busy", a_busy, 1'b0);
        check("rst_done", b_done, 1'b0);
        check("rst_cnt", b_cnt, 8'd0);
        reset = 1'b1;
        // Basic handshake
        drive(1'b1, 8'h00, 8'h00); tick();
        go = 1'b1; d1 = 8'hA5; d0 = 8'h5A; tick(); tick();
        check("basic_done", a_done, 1'b1);
        check("basic_valid", b_valid, 1'b1);
        check("basic_data", a_data, 8'hA5);
        check("basic_cnt", b_cnt, 8'd1);
        drive(1'b0, 8'h00, 8'h00); tick();
        check("basic_hold", a_done, 1'b1);
        tick();
        check("basic_fall", a_done, 1'b0);
        // Partial arrival: dut_a times out, dut_b waits for the full word
        drive(1'b1, 8'h00, 8'h00); tick(); tick();
        pulses = 0;
        m = 8'h00;
        for (int k = 0; k < 8; k++) begin
            m = {m[6:0], 1'b1};
            drive(1'b1, m, 8'h3C); tick();
            pulses += int'(b_valid);
        end
        check("partial_no_early_done", b_done, 1'b0);
        tick(); pulses += int'(b_valid);
        check("partial_done", b_done, 1'b1);
        tick(); pulses += int'(b_valid);
        check("partial_pulses", pulses, 1);
        check("partial_a_timeout", a_et, 1'b1);
        drive(1'b0, 8'h00, 8'h00); tick(); tick();
        check("to_cleared", a_et, 1'b0);
        // Illegal code during WAIT_DATA
        drive(1'b1, 8'h00, 8'h00); tick(); tick();
        go = 1'b1; d1 = 8'h08; d0 = 8'h08; tick(); tick();
        check("ill_flag", b_ei, 1'b1);
        check("ill_done", b_done, 1'b0);
        check("ill_busy", b_busy, 1'b1);
        drive(1'b0, 8'h00, 8'h00); tick(); tick();
        check("ill_clear", b_ei, 1'b0);
        check("ill_idle", b_busy, 1'b0);
        // Valid data held after go falls
        drive(1'b1, 8'h00, 8'h00); tick();
        drive(1'b1, 8'hFF, 8'h77); tick(); tick();
        drive(1'b0, 8'hFF, 8'h77); tick(); tick();
        check("nonull_b_fall", b_done, 1'b0);
        tick(); tick(); tick(); tick();
        check("done_timeout", a_et, 1'b1);
        drive(1'b0, 8'h00, 8'h00); tick(); tick();
        // Abort in WAIT_DATA
        saved = int'(b_cnt);
        drive(1'b1, 8'h00, 8'h00); tick(); tick();
        drive(1'b0, 8'h00, 8'h00); tick(); tick();
        check("abort_idle", b_busy, 1'b0);
        check("abort_cnt", b_cnt, saved);
        // Counter wrap from a fresh reset
        reset = 1'b0; tick(); reset = 1'b1;
        for (int k = 0; k < 5; k++) handshake(8'(k * 37 + 1));
        check("wrap_a", a_cnt, 2'd1);
        check("wrap_b", b_cnt, 8'd5);
        // Reset while acknowledging
        drive(1'b1, 8'h00, 8'h00); tick();
        drive(1'b1, 8'hFF, 8'hC3); tick(); tick();
        check("mid_done", a_done, 1'b1);
        reset = 1'b0; tick(); reset = 1'b1;
        check("mid_rst_done", a_done, 1'b0);
        check("mid_rst_cnt", b_cnt, 8'd0);
        check("mid_rst_busy", a_busy, 1'b0);
        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 9) == 0) go = ~go;
            if ($urandom_range(0, 9) < 3) begin
                case ($urandom_range(0, 9))
                    0, 1, 2:    drive(go, 8'h00, 8'h00);
                    3, 4, 5, 6: drive(go, 8'hFF, 8'($urandom));
                    7, 8:       drive(go, 8'($urandom), 8'($urandom));
                    default: begin
                        d1 = 8'($urandom);
                        d0 = ($urandom_range(0, 2) == 0) ? 8'($urandom) : ~d1;
                    end
                endcase
            end
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
